// File: rtl/fetch_busio.sv
// Instruction-port responder: serves fetch from a one-entry buffer and refills it
// over a single-outstanding valid/ready read, dropping responses made stale by redirect or invalidate.
module fetch_busio #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_address,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,
    input  logic        invalidate,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_address,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a request transfers on the cycle mem_req_valid && mem_req_ready;
    // valid and address stay stable until then, and exactly one response follows.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_buf_valid;
    logic [29:0] r_buf_tag;
    logic [31:0] r_buf_data;
    logic [29:0] r_req_tag;
    logic        r_inval_pend;

    logic        w_hit;
    logic        w_fill;
    logic        w_load_req;

    assign w_hit = r_buf_valid && (r_buf_tag == fetch_address[31:2]);

    // A response only fills when nothing has invalidated it and fetch still wants that word.
    assign w_fill = (r_state == S_WAIT) && mem_resp_valid && !r_inval_pend && !invalidate
                    && (r_req_tag == fetch_address[31:2]);

    assign w_load_req = (r_state == S_IDLE) && !invalidate && !w_hit;

    assign fetch_ready     = w_hit;
    assign fetch_data      = w_hit ? r_buf_data : NOP_INSTR;
    assign mem_req_valid   = (r_state == S_REQ);
    assign mem_req_address = {r_req_tag, 2'b00};
    assign o_dbg_state     = r_state;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (!invalidate && !w_hit) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_buf_valid  <= 1'b0;
            r_inval_pend <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (invalidate) begin
                r_buf_valid <= 1'b0;
            end else if (w_fill) begin
                r_buf_valid <= 1'b1;
            end
            // Pending flag lives only while a request is in flight.
            if (w_next_state == S_IDLE) begin
                r_inval_pend <= 1'b0;
            end else if (invalidate) begin
                r_inval_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_buf_tag  <= r_req_tag;
            r_buf_data <= mem_resp_data;
        end
        if (w_load_req) begin
            r_req_tag <= fetch_address[31:2];
        end
    end

endmodule
